// File: rtl/ddfs_lut_scheduler.sv
// ddfs_lut_scheduler: two-channel DDFS sharing one sine LUT between phase accumulators A and B
//   clk, rst_n        clock, async active-low reset
//   en, sample_tick   a tick is accepted in IDLE only while en is high
//   cfg_*             valid/ready config port: 00 FTW, 01 phase offset, 10 clear acc, 11 no-op
//   sample_a/b        registered two's-complement samples
//   out_valid         pulses in UPD when the new sample pair is visible
//   busy, overrun     not-IDLE flag, and a pulse for a tick dropped while busy

module sine_wave_lut_8bit (
   input  logic [7:0] addr,
   output logic [7:0] q
);
   // quarter-wave table of round(64*sin(2*pi*k/256)), k = 0..64
   localparam int qtab [65] = '{
      0, 2, 3, 5, 6, 8, 9, 11, 12, 14,
      16, 17, 19, 20, 22, 23, 24, 26, 27, 29,
      30, 32, 33, 34, 36, 37, 38, 39, 41, 42,
      43, 44, 45, 46, 47, 48, 49, 50, 51, 52,
      53, 54, 55, 56, 56, 57, 58, 59, 59, 60,
      60, 61, 61, 62, 62, 62, 63, 63, 63, 64,
      64, 64, 64, 64, 64};
   logic [6:0] idx;
   logic [7:0] mag;
   always_comb begin
      idx = addr[6] ? 7'd64 - {1'b0, addr[5:0]} : {1'b0, addr[5:0]};
      mag = 8'(qtab[idx]);
      q = addr[7] ? 8'd0 - mag : mag;
   end
endmodule

module ddfs_lut_scheduler #(
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sample_tick,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             cfg_ch,
   input  logic [1:0]       cfg_cmd,
   input  logic [ACC_W-1:0] cfg_data,
   output logic [7:0]       sample_a,
   output logic [7:0]       sample_b,
   output logic             out_valid,
   output logic             busy,
   output logic             overrun
);
   typedef enum logic [1:0] {IDLE, RD_A, RD_B, UPD} state_t;
   state_t state, state_nx;
   logic [ACC_W-1:0] acc_a, acc_b, ftw_a, ftw_b;
   logic [7:0] poff_a, poff_b, lut_addr, lut_q;
   logic tick, cfg_go;

   sine_wave_lut_8bit u_lut (.addr(lut_addr), .q(lut_q));

   always_comb begin
      tick = sample_tick & en;
      busy = state != IDLE;
      out_valid = state == UPD;
      overrun = tick & busy;
      // held low while reset is asserted so the host sees no handshake window
      cfg_ready = rst_n & (state == IDLE);
      cfg_go = cfg_valid & cfg_ready;
      state_nx = state == IDLE ? (tick ? RD_A : IDLE) :
                 state == RD_A ? RD_B :
                 state == RD_B ? UPD : IDLE;
      // channel A addressing doubles as the deterministic idle address
      lut_addr = state == RD_B ? acc_b[ACC_W-1 -: 8] + poff_b : acc_a[ACC_W-1 -: 8] + poff_a;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc_a <= '0;
         acc_b <= '0;
         ftw_a <= '0;
         ftw_b <= '0;
         poff_a <= '0;
         poff_b <= '0;
         sample_a <= '0;
         sample_b <= '0;
      end else begin
         state <= state_nx;
         // config lands only in IDLE, so it never collides with the UPD accumulate
         if (cfg_go && cfg_cmd == 2'b00 && !cfg_ch) ftw_a <= cfg_data;
         if (cfg_go && cfg_cmd == 2'b00 && cfg_ch) ftw_b <= cfg_data;
         if (cfg_go && cfg_cmd == 2'b01 && !cfg_ch) poff_a <= cfg_data[7:0];
         if (cfg_go && cfg_cmd == 2'b01 && cfg_ch) poff_b <= cfg_data[7:0];
         if (cfg_go && cfg_cmd == 2'b10 && !cfg_ch) acc_a <= '0;
         if (cfg_go && cfg_cmd == 2'b10 && cfg_ch) acc_b <= '0;
         if (state == RD_A) sample_a <= lut_q;
         if (state == RD_B) sample_b <= lut_q;
         if (state == UPD) begin
            acc_a <= acc_a + ftw_a;
            acc_b <= acc_b + ftw_b;
         end
      end
   end
endmodule

// File: tb/tb_ddfs_lut_scheduler.sv
// tb_ddfs_lut_scheduler: randomized and directed checks of ddfs_lut_scheduler against a transaction-level model
module tb_ddfs_lut_scheduler;
   logic clk = 0, rst_n, en, sample_tick, cfg_valid, cfg_ch;
   logic [1:0] cfg_cmd;
   logic [31:0] cfg_data;
   logic cfg_ready, out_valid, busy, overrun;
   logic [7:0] sample_a, sample_b, ga, gb;
   int checks = 0, errors = 0;
   logic [31:0] m_acc [2];
   logic [31:0] m_ftw [2];
   logic [7:0] m_poff [2];
   logic [7:0] basic_a [4] = '{8'h00, 8'h02, 8'h03, 8'h05};
   logic [7:0] basic_b [4] = '{8'h00, 8'h40, 8'h00, 8'hC0};
   logic [7:0] wrap_a [5] = '{8'h00, 8'hC0, 8'h00, 8'h40, 8'h00};

   always #5 clk = ~clk;

   ddfs_lut_scheduler #(.ACC_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sample_tick(sample_tick),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_cmd(cfg_cmd),
      .cfg_data(cfg_data), .sample_a(sample_a), .sample_b(sample_b),
      .out_valid(out_valid), .busy(busy), .overrun(overrun));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] sine_ref(input logic [7:0] a);
      real v;
      int r;
      v = 64.0 * $sin(2.0 * 3.141592653589793 * real'(a) / 256.0);
      r = v >= 0.0 ? int'($floor(v + 0.5)) : -int'($floor(0.5 - v));
      return r[7:0];
   endfunction

   function automatic logic [7:0] exp_s(input int c);
      logic [7:0] ad;
      ad = m_acc[c][31:24] + m_poff[c];
      return sine_ref(ad);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         m_acc[i] = 0;
         m_ftw[i] = 0;
         m_poff[i] = 0;
      end
   endtask

   task automatic m_cfg(input logic ch, input logic [1:0] cmd, input logic [31:0] data);
      if (cmd == 2'b00) m_ftw[ch] = data;
      if (cmd == 2'b01) m_poff[ch] = data[7:0];
      if (cmd == 2'b10) m_acc[ch] = 0;
   endtask

   task automatic m_step();
      for (int i = 0; i < 2; i++) m_acc[i] = m_acc[i] + m_ftw[i];
   endtask

   task automatic do_cfg(input logic ch, input logic [1:0] cmd, input logic [31:0] data);
      int n = 0;
      cfg_valid = 1;
      cfg_ch = ch;
      cfg_cmd = cmd;
      cfg_data = data;
      @(negedge clk);
      while (!cfg_ready && n < 10) begin
         n++;
         @(negedge clk);
      end
      check("cfg_ready", 32'(cfg_ready), 1);
      @(posedge clk);
      #1 cfg_valid = 0;
      m_cfg(ch, cmd, data);
   endtask

   task automatic do_tick(input logic cv, input logic ch, input logic [1:0] cmd,
                          input logic [31:0] data, input logic drop,
                          output logic [7:0] oa, output logic [7:0] ob);
      int n = 0;
      sample_tick = 1;
      en = 1;
      if (cv) begin
         cfg_valid = 1;
         cfg_ch = ch;
         cfg_cmd = cmd;
         cfg_data = data;
      end
      @(negedge clk);
      check("tick_overrun", 32'(overrun), 0);
      @(posedge clk);
      #1 sample_tick = 0;
      cfg_valid = 0;
      if (drop) en = 0;
      if (cv) m_cfg(ch, cmd, data);
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 8);
      check("latency", n, 3);
      oa = sample_a;
      ob = sample_b;
      check("sample_a", 32'(sample_a), 32'(exp_s(0)));
      check("sample_b", 32'(sample_b), 32'(exp_s(1)));
      m_step();
      @(posedge clk);
      #1 en = 1;
      check("idle_after", 32'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst_n = 0; en = 0; sample_tick = 0; cfg_valid = 0; cfg_ch = 0; cfg_cmd = 0; cfg_data = 0;
      m_reset();
      repeat (3) @(negedge clk);
      check("rst_cfg_ready", 32'(cfg_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_samples", {16'd0, sample_a, sample_b}, 0);
      @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      check("rel_cfg_ready", 32'(cfg_ready), 1);
      check("rel_busy", 32'(busy), 0);
      @(posedge clk);
      #1;

      do_cfg(0, 2'b00, 32'h0100_0000);
      do_cfg(1, 2'b00, 32'h4000_0000);
      for (int i = 0; i < 4; i++) begin
         do_tick(0, 0, 0, 0, 0, ga, gb);
         check("basic_a", 32'(ga), 32'(basic_a[i]));
         check("basic_b", 32'(gb), 32'(basic_b[i]));
      end

      do_cfg(1, 2'b00, 0);
      do_cfg(1, 2'b10, 0);
      do_cfg(1, 2'b01, 64);
      repeat (2) begin
         do_tick(0, 0, 0, 0, 0, ga, gb);
         check("poff64_b", 32'(gb), 32'h40);
      end
      do_cfg(1, 2'b01, 192);
      repeat (2) begin
         do_tick(0, 0, 0, 0, 0, ga, gb);
         check("poff192_b", 32'(gb), 32'hC0);
      end

      do_cfg(0, 2'b10, 0);
      do_cfg(0, 2'b00, 32'hC000_0000);
      for (int i = 0; i < 5; i++) begin
         do_tick(0, 0, 0, 0, 0, ga, gb);
         check("wrap_a", 32'(ga), 32'(wrap_a[i]));
      end

      sample_tick = 1;
      en = 1;
      @(posedge clk);
      #1 cfg_valid = 1;
      cfg_ch = 0;
      cfg_cmd = 2'b00;
      cfg_data = 32'h0200_0000;
      @(negedge clk);
      check("ovr_pulse", 32'(overrun), 1);
      check("ovr_stall_rdy1", 32'(cfg_ready), 0);
      check("ovr_busy", 32'(busy), 1);
      @(posedge clk);
      #1 sample_tick = 0;
      @(negedge clk);
      check("ovr_pulse_gone", 32'(overrun), 0);
      check("ovr_stall_rdy2", 32'(cfg_ready), 0);
      check("ovr_valid_early", 32'(out_valid), 0);
      @(negedge clk);
      check("ovr_valid", 32'(out_valid), 1);
      check("ovr_stall_rdy3", 32'(cfg_ready), 0);
      check("ovr_sample_a", 32'(sample_a), 32'(exp_s(0)));
      check("ovr_sample_b", 32'(sample_b), 32'(exp_s(1)));
      m_step();
      @(negedge clk);
      check("ovr_idle_rdy", 32'(cfg_ready), 1);
      check("ovr_single_valid", 32'(out_valid), 0);
      @(posedge clk);
      #1 cfg_valid = 0;
      m_cfg(0, 2'b00, 32'h0200_0000);
      repeat (3) begin
         @(negedge clk);
         check("ovr_no_extra", {30'd0, out_valid, busy}, 0);
      end
      @(posedge clk);
      #1 do_tick(0, 0, 0, 0, 0, ga, gb);

      en = 0;
      sample_tick = 1;
      @(negedge clk);
      check("en0_overrun", 32'(overrun), 0);
      @(posedge clk);
      #1 sample_tick = 0;
      repeat (4) begin
         @(negedge clk);
         check("en0_quiet", {30'd0, out_valid, busy}, 0);
      end
      @(posedge clk);
      #1 en = 1;

      do_cfg(0, 2'b10, 0);
      do_cfg(0, 2'b01, 0);
      do_cfg(0, 2'b00, 32'h0A00_0000);
      do_tick(0, 0, 0, 0, 0, ga, gb);
      do_tick(1, 0, 2'b10, 0, 0, ga, gb);
      check("simul_clear_a", 32'(ga), 0);

      for (int i = 0; i < 40; i++) begin
         logic rc, rv, rd;
         logic [1:0] rm;
         logic [31:0] rdat;
         rc = 1'($urandom_range(0, 1));
         rm = 2'($urandom_range(0, 3));
         rdat = $urandom;
         if ($urandom_range(0, 1) == 1) do_cfg(rc, rm, rdat);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         rc = 1'($urandom_range(0, 1));
         rm = 2'($urandom_range(0, 3));
         rdat = $urandom;
         rv = $urandom_range(0, 2) == 0;
         rd = $urandom_range(0, 3) == 0;
         do_tick(rv, rc, rm, rdat, rd, ga, gb);
      end

      do_cfg(0, 2'b00, 32'h1234_5678);
      do_cfg(1, 2'b00, 32'h9ABC_DEF0);
      sample_tick = 1;
      en = 1;
      @(posedge clk);
      #1 sample_tick = 0;
      @(negedge clk);
      @(negedge clk);
      check("mid_busy", 32'(busy), 1);
      rst_n = 0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_samples", {16'd0, sample_a, sample_b}, 0);
      @(negedge clk);
      check("mid_rst_valid2", 32'(out_valid), 0);
      @(posedge clk);
      #1 rst_n = 1;
      m_reset();
      @(negedge clk);
      check("mid_rel_rdy", 32'(cfg_ready), 1);
      @(posedge clk);
      #1 do_tick(0, 0, 0, 0, 0, ga, gb);
      check("post_rst_pair", {16'd0, ga, gb}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ddfs_lut_scheduler.md
Name: ddfs_lut_scheduler

Overview:
Two-channel DDFS core. It time-multiplexes a single sine_wave_lut_8bit instance (8-bit address in, 8-bit two's-complement sample out, combinational) between two phase accumulators, A and B. A host configures the block through a valid/ready port: frequency tuning word (FTW), phase offset, and phase clear. On each sample tick the block produces one registered sample pair.

Parameters:
ACC_W, 32, phase accumulator width. Must be ≥ 8. LUT address = acc[ACC_W-1 -: 8].

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; ticks ignored while low
sample_tick  in  1  single-cycle request for one new sample pair
cfg_valid  in  1  config request
cfg_ready  out  1  high only in IDLE
cfg_ch  in  1  target channel: 0=A, 1=B
cfg_cmd  in  2  00 load FTW, 01 load phase offset, 10 clear accumulator, 11 reserved
cfg_data  in  ACC_W  FTW value, or phase offset in [7:0]
sample_a  out  8  channel A sample, two's complement
sample_b  out  8  channel B sample, two's complement
out_valid  out  1  one-cycle pulse when sample_a/sample_b update
busy  out  1  high in any state other than IDLE
overrun  out  1  one-cycle pulse when an accepted-eligible tick is dropped

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - acc_a, acc_b, ftw_a, ftw_b, poff_a, poff_b = 0.
  - All outputs 0, except cfg_ready=1 after release.
- FSM states: IDLE -> RD_A -> RD_B -> UPD -> IDLE.
  - IDLE: tick accepted when sample_tick&en; next state RD_A.
  - RD_A: LUT address = acc_a[ACC_W-1 -: 8] + poff_a (mod 256). q registered into sample_a at end of cycle.
  - RD_B: same for channel B into sample_b.
  - UPD: out_valid=1. acc_a += ftw_a, acc_b += ftw_b, both mod 2^ACC_W.
- Latency: tick sampled at edge T. out_valid high in cycle T+3, with sample_a/sample_b already holding new values. Samples hold until the next update.
- Max rate: one accepted tick per 4 cycles.
- LUT address outside RD_A/RD_B: drive acc_a-based address. The value is don't-care but must be deterministic.
- Config port:
  - Handshake completes on cfg_valid&cfg_ready. cfg_ready=1 only in IDLE.
  - Register updates on the same edge as the handshake.
  - cmd 11 is accepted with no effect.
  - cfg_valid while busy: stalls until IDLE. The host must hold cfg_valid and its fields.
- Simultaneous cfg handshake and tick in IDLE: both take effect. The new FTW/offset/clear is visible to that tick's RD_A/RD_B, because register update precedes the read.
- FTW load does not change acc. The first sample after a load uses the current acc.
- Clear sets acc for the selected channel to 0. It does not touch ftw or poff.
- Tick with en=1 while busy: dropped, overrun pulses that cycle, accumulators unaffected.
- Tick with en=0: ignored, no overrun.
- en falling mid-sequence: the sequence completes normally, including UPD.
- Reset mid-sequence: no out_valid, everything returns to reset values immediately.
- Accumulator wrap is silent modular arithmetic.

Test Plan:
- Basic stepping. Setup: reset, cfg FTW_A=0x0100_0000 (step 1), FTW_B=0x4000_0000 (step 64), then ticks every 4 cycles. Expected:
  - sample pairs (A,B) = (0x00,0x00), (0x02,0x40), (0x03,0x00), (0x05,0xC0).
  - out_valid exactly 3 cycles after each tick.
- Phase offset. Setup: cfg B offset=64 with FTW_B=0. Expected: every sample_b=0x40. Then offset=192: sample_b=0xC0. A unaffected.
- Wrap. Setup: FTW_A=0xC000_0000, 5 ticks. Expected: sample_a = 0x00, 0xC0, 0x00, 0x40, 0x00 (addresses 0, 192, 128, 64, 0).
- Overrun/handshake:
  - Ticks at T and T+1: one out_valid at T+3, overrun pulse at T+1.
  - cfg_valid held at T+1: cfg_ready low until IDLE at T+4, handshake there.
  - Tick with en=0: no out_valid, no overrun.
- Simultaneous events. Setup: in IDLE, cfg clear A together with a tick, while acc_a sits at address 10. Expected: sample_a=0x00 (address 0), not 0x10.
- Reset mid-operation. Setup: deassert rst_n during RD_B. Expected:
  - No out_valid, sample_a/b=0, busy=0.
  - After release, a tick yields (0x00,0x00), since FTWs were cleared.
